// File: rtl/cic_seq_ctrl.sv
// Sample sequencer feeding a CIC interpolator: 4-deep input FIFO, strobe every R_lat cycles.
// Optional macro CIC_SEQ_UNDERRUN_EN: empty-FIFO strobes emit a zero sample and set sticky underrun.
module cic_seq_ctrl #(
    parameter int Win       = 16,
    parameter int RW        = 8,
    parameter int FLUSH_CYC = 8   // must be >= 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [RW-1:0]  ratio,
    input  logic [Win-1:0] s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [Win-1:0] cic_data,
    output logic           cic_val,
    output logic           busy,
    output logic           underrun,
    output logic [2:0]     fill
);

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  r_lat_q, r_lat_d;
    logic [FW-1:0]  fcnt_q, fcnt_d;
    logic           strobe;

    logic [Win-1:0] mem [4];
    logic [1:0]     wr_ptr, rd_ptr;
    logic [2:0]     fill_q;
    logic           push, pop, fifo_empty;

    logic           cic_val_q;
    logic [Win-1:0] cic_data_q;

    assign fifo_empty = (fill_q == 3'd0);
    assign s_ready    = (fill_q < 3'd4) && (state_q != FLUSH);
    assign push       = s_valid && s_ready;
    // Pop reads the registered head only; a same-edge push lands behind it.
    assign pop        = strobe && !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_lat_d = r_lat_q;
        fcnt_d  = fcnt_q;
        strobe  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    state_d = RUN;
                    r_lat_d = (ratio == '0) ? RW'(1) : ratio;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    if (!en) begin
                        state_d = FLUSH;
                        fcnt_d  = '0;
                    end else begin
                        strobe = 1'b1;
                        cnt_d  = r_lat_q - RW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - RW'(1);
                end
            end
            FLUSH: begin
                if (fcnt_q == FW'(FLUSH_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_lat_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_lat_q <= r_lat_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + 3'd1;
                2'b01:   fill_q <= fill_q - 3'd1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

`ifdef CIC_SEQ_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cic_val_q  <= 1'b0;
            cic_data_q <= '0;
            underrun_q <= 1'b0;
        end else begin
            cic_val_q <= strobe;
            if (pop) begin
                cic_data_q <= mem[rd_ptr];
            end else if (strobe) begin
                cic_data_q <= '0;
                underrun_q <= 1'b1;
            end
        end
    end

    assign underrun = underrun_q;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cic_val_q  <= 1'b0;
            cic_data_q <= '0;
        end else begin
            cic_val_q <= pop;
            if (pop) cic_data_q <= mem[rd_ptr];
        end
    end

    assign underrun = 1'b0;
`endif

    assign cic_val  = cic_val_q;
    assign cic_data = cic_data_q;
    assign busy     = (state_q != IDLE);
    assign fill     = fill_q;

endmodule

// File: tb/tb_cic_seq_ctrl.sv
// Directed self-checking bench for cic_seq_ctrl; outputs sampled on the falling clock edge.
module tb_cic_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  ratio;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] cic_data;
    logic        cic_val;
    logic        busy;
    logic        underrun;
    logic [2:0]  fill;

    int n_checks = 0;
    int n_fail   = 0;

    cic_seq_ctrl #(.Win(16), .RW(8), .FLUSH_CYC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ratio    (ratio),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .cic_data (cic_data),
        .cic_val  (cic_val),
        .busy     (busy),
        .underrun (underrun),
        .fill     (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ratio = '0; s_data = '0; s_valid = 1'b0;
        #2 rst = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_fill", fill, 0);
        check("rst_val", cic_val, 0);
        check("rst_data", cic_data, 0);
        check("rst_underrun", underrun, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_fill", fill, 0);
        check("idle_ready", s_ready, 1);
        check("idle_val", cic_val, 0);

        // ratio 4, three samples, strobes 4 cycles apart
        ratio = 8'd4;
        push(16'h0011); push(16'h0022); push(16'h0033);
        check("t2_fill3", fill, 3);
        en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check("t2_val", cic_val, (k == 2 || k == 6 || k == 10) ? 1 : 0);
            if (k == 1)  check("t2_busy", busy, 1);
            if (k == 2)  check("t2_d0", cic_data, 16'h0011);
            if (k == 4)  check("t2_hold", cic_data, 16'h0011);
            if (k == 6)  check("t2_d1", cic_data, 16'h0022);
            if (k == 10) check("t2_d2", cic_data, 16'h0033);
            if (k == 10) check("t2_fill0", fill, 0);
        end
        en = 1'b0;
        for (int k = 14; k <= 21; k++) begin
            @(negedge clk);
            check("t2_flush_val", cic_val, 0);
            check("t2_flush_ready", s_ready, 0);
            check("t2_flush_busy", busy, 1);
        end
        @(negedge clk);
        check("t2_idle", busy, 0);

        // five back-to-back pushes, only four fit
        ratio = 8'd1;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h00A1 + 16'(i);
            @(negedge clk);
            if (i == 3) begin
                check("t3_fill4", fill, 4);
                check("t3_ready0", s_ready, 0);
            end
        end
        s_valid = 1'b0;
        check("t3_fill_after5", fill, 4);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t3_val", cic_val, (k >= 2) ? 1 : 0);
            if (k >= 2) check("t3_data", cic_data, 16'h00A1 + 16'(k - 2));
        end
        en = 1'b0;
        wait_idle();
        check("t3_fill_end", fill, 0);

        // single sample, ratio 2: second strobe finds the FIFO empty
        ratio = 8'd2;
        push(16'h0055);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) begin
                check("t4_val1", cic_val, 1);
                check("t4_d1", cic_data, 16'h0055);
            end
            if (k == 3) check("t4_hold", cic_data, 16'h0055);
`ifdef CIC_SEQ_UNDERRUN_EN
            if (k == 4) begin
                check("t4_uval", cic_val, 1);
                check("t4_udata", cic_data, 0);
                check("t4_uflag", underrun, 1);
            end
`else
            if (k == 4) begin
                check("t4_uval", cic_val, 0);
                check("t4_udata", cic_data, 16'h0055);
                check("t4_uflag", underrun, 0);
            end
`endif
        end
        en = 1'b0;
        wait_idle();

        // en dropped mid-RUN, ratio 3
        ratio = 8'd3;
        push(16'h0061); push(16'h0062);
        en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 2) check("t5_d0", cic_data, 16'h0061);
            if (k == 3) en = 1'b0;
            if (k >= 3 && k <= 12) check("t5_val", cic_val, 0);
            if (k == 5) check("t5_busy", busy, 1);
            if (k >= 5 && k <= 12) check("t5_ready", s_ready, 0);
            if (k == 13) begin
                check("t5_idle", busy, 0);
                check("t5_ready1", s_ready, 1);
                check("t5_retained", fill, 1);
            end
        end

        // ratio 0 acts as 1; ratio change in RUN ignored; push+pop on same edge
        push(16'h0071); push(16'h0072);
        check("t6_fill3", fill, 3);
        ratio = 8'd0;
        en = 1'b1;
        @(negedge clk);
        ratio = 8'd5;
        @(negedge clk);
        check("t6_v2", cic_val, 1);
        check("t6_d2", cic_data, 16'h0062);
        check("t6_f2", fill, 2);
        s_valid = 1'b1; s_data = 16'h0073;
        @(negedge clk);
        s_valid = 1'b0;
        check("t6_v3", cic_val, 1);
        check("t6_d3", cic_data, 16'h0071);
        check("t6_f3", fill, 2);
        @(negedge clk);
        check("t6_v4", cic_val, 1);
        check("t6_d4", cic_data, 16'h0072);
        check("t6_f4", fill, 1);
        @(negedge clk);
        check("t6_v5", cic_val, 1);
        check("t6_d5", cic_data, 16'h0073);
        check("t6_f5", fill, 0);
        en = 1'b0;
        wait_idle();

        // asynchronous reset in the middle of RUN
        ratio = 8'd4;
        push(16'h0081); push(16'h0082);
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("t7_pre_val", cic_val, 1);
        #2 rst = 1'b0;
        #1;
        check("t7_busy", busy, 0);
        check("t7_fill", fill, 0);
        check("t7_val", cic_val, 0);
        check("t7_data", cic_data, 0);
        check("t7_underrun", underrun, 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t7_ready", s_ready, 1);
        check("t7_idle", busy, 0);
        check("t7_nostrobe", cic_val, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/cic_seq_ctrl.md
CIC_SEQ_CTRL -- requirements
Module: cic_seq_ctrl

Interface
REQ-001 SHALL have parameter Win, default 16, sample width fed to the CIC interpolator.
REQ-002 SHALL have parameter RW, default 8, width of the rate-ratio port.
REQ-003 SHALL have parameter FLUSH_CYC, default 8, the idle cycles allowed for the CIC pipeline to empty after a stop.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, run request from the system.
REQ-007 SHALL have port ratio, input, RW, the cycle period between CIC input strobes.
REQ-008 SHALL have port s_data, input, Win, the upstream sample.
REQ-009 SHALL have port s_valid, input, 1, upstream sample valid.
REQ-010 SHALL have port s_ready, output, 1, a 4-entry FIFO slot is available.
REQ-011 SHALL have port cic_data, output, Win, driving the CIC i_data.
REQ-012 SHALL have port cic_val, output, 1, driving the CIC val_in.
REQ-013 SHALL have port busy, output, 1, asserted whenever the state is not IDLE.
REQ-014 SHALL have port underrun, output, 1, sticky flag for a strobe issued with an empty FIFO.
REQ-015 SHALL have port fill, output, 3, current FIFO occupancy (0..4).

Function
REQ-016 SHALL accept a sample into a 4-deep FIFO on any edge where s_valid and s_ready are both 1.
REQ-017 SHALL drive s_ready = (fill<4) and (state!=FLUSH), derived from registered state only.
REQ-018 SHALL implement states IDLE, RUN and FLUSH.
REQ-019 IDLE SHALL go to RUN when en=1 and fill>0; at that edge it latches ratio into R_lat (ratio=0 latched as 1) and clears the period counter cnt to 0.
REQ-020 In RUN, on an edge with cnt==0, SHALL do all of: set cic_val=1, set cic_data to the popped FIFO head, and load cnt=R_lat-1; otherwise SHALL do cnt=cnt-1 and cic_val=0.
REQ-021 SHALL register cic_val and cic_data so that cic_val is a single-cycle pulse, the first one cycle after RUN entry, then exactly every R_lat cycles.
REQ-022 SHALL ignore changes on ratio while in RUN.
REQ-023 RUN SHALL go to FLUSH on a strobe edge (cnt==0) where en=0, and that edge SHALL issue no strobe.
REQ-024 FLUSH SHALL keep cic_val=0, refuse input, count FLUSH_CYC cycles, then go to IDLE; FIFO contents SHALL be retained.
REQ-025 On simultaneous push and pop, fill SHALL be unchanged and both operations SHALL take effect.
REQ-026 A pop SHALL see only registered FIFO contents, so a sample pushed on the same edge is not popped.
REQ-027 cic_data SHALL hold its value between strobes.

Reset
REQ-028 While rst=0, all outputs and state SHALL be cleared asynchronously: state=IDLE, cnt=0, FIFO empty, cic_val=0, cic_data=0, busy=0, underrun=0, fill=0, and s_ready=1 once rst=1.
REQ-029 A reset during RUN or FLUSH SHALL discard all FIFO contents and any pending strobe.

Configuration
REQ-030 With macro CIC_SEQ_UNDERRUN_EN defined, a strobe edge with an empty FIFO SHALL still assert cic_val with cic_data=0 and SHALL set underrun, which stays 1 until reset.
REQ-031 Without CIC_SEQ_UNDERRUN_EN, a strobe edge with an empty FIFO SHALL skip the strobe (cic_val=0), cnt SHALL reload normally, and underrun SHALL be tied to 0.

Verification
REQ-032 Reset then idle -> busy=0, fill=0, s_ready=1, cic_val=0.
REQ-033 ratio=4; push 0x0011, 0x0022, 0x0033; en=1 -> three cic_val pulses 4 cycles apart carrying 0x0011, 0x0022, 0x0033 in order; fill returns to 0.
REQ-034 Push 5 samples back-to-back with en=0 -> s_ready drops after the 4th push and fill=4; the 5th sample is not accepted.
REQ-035 ratio=2, 1 sample, en held 1 -> 2nd strobe: with CIC_SEQ_UNDERRUN_EN, cic_val=1, cic_data=0, underrun=1; without it, no pulse and underrun=0.
REQ-036 en dropped mid-RUN with ratio=3 -> no strobe at the next cnt==0 edge; FLUSH lasts 8 cycles with s_ready=0; then IDLE and busy=0.
REQ-037 ratio=0 and ratio changed to 5 during RUN -> strobes on consecutive cycles, and the period is unchanged until the next IDLE.
